muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide unit that consumes the register-file read ports (A as operand `a`, B as operand `b`) in the execute stage and owns the architectural HI/LO registers. It implements MULT, MULTU, DIV and DIVU with a start/busy/done handshake, and supports direct HI/LO writes for MTHI/MTLO. The MFHI/MFLO path reads `hi`/`lo` directly.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; iteration count equals `WIDTH`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request an operation; sampled only when `busy`=0.
- `op` in 2: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with `start`.
- `a` in WIDTH: multiplicand or dividend (register A).
- `b` in WIDTH: multiplier or divisor (register B).
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in WIDTH: data for MTHI/MTLO.
- `busy` out 1: iteration in progress.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `hi` out WIDTH: HI register (product high word or remainder).
- `lo` out WIDTH: LO register (product low word or quotient).

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE after `WIDTH` iterations.
  - DONE→RUN on `start`, otherwise DONE→IDLE.
- On acceptance, latch `op`, the operand magnitudes and the result sign. Signed ops take absolute values and record the sign. Unsigned ops use operands as-is.
- Multiply uses radix-2 shift-add, one bit per cycle, with a 2·WIDTH accumulator.
- Divide uses restoring division, one quotient bit per cycle.
- Sign fix at completion:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Quotient truncates toward zero.
- Divide by zero (signed or unsigned): HI=`a` as latched, LO=all ones. Iterations still run, so latency is unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- HI/LO are written only on the RUN→DONE edge. Operands are not re-read after acceptance, so `a`/`b` may change freely during RUN.
- `hi_we`/`lo_we`:
  - Ignored while `busy`=1.
  - Otherwise applied at the next edge.
  - If asserted in the same cycle as an accepted `start`, the write is applied and is later overwritten by the result.
- `start` while `busy`=1 is ignored. Nothing is queued.
- Reset, including mid-operation: state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, iteration counter=0. The aborted operation has no effect.

## Timing
- Edge E0 samples `start`=1. `busy`=1 from E0 through E32, which is exactly WIDTH cycles.
- Edge E32 writes HI/LO, drops `busy` and raises `done`. `done`=1 for the single cycle E32–E33.
- Latency is WIDTH+1 edges from the accepting edge to the first edge at which `done` is observed high. It is the same for all ops and all operand values.
- Back-to-back operation: `start` during the DONE cycle is accepted at E33, and `busy` rises in the same cycle that `done` falls.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - state enum IDLE/RUN/DONE.
  - `WIDTH` default constant.
  - DIV0_LO constant (all ones).
- One natural sub-module, `muldiv_signfix`: combinational two's-complement negation of the 2·WIDTH result and quotient/remainder selection. Reused for operand absolute value.
- Counter width is clog2(WIDTH)+1.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `done` is seen exactly 33 edges after the accepting edge, and `busy` is high for 32 cycles.
- MULT a=0xFFFFFFFD (−3), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 → LO=14, HI=2.
- DIV a=0x1234, b=0 → HI=0x1234, LO=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- While busy:
  - Pulse `start` with new operands → ignored; the result matches the original op.
  - `hi_we`=1, `wdata`=0xDEAD → ignored.
  - After `done`, `lo_we`=1 with `wdata`=0xBEEF → LO=0xBEEF next cycle.
- Assert `rst` 10 cycles into a DIVU → `busy`=0, `done`=0, HI=LO=0 immediately (asynchronous). No `done` pulse follows. A fresh op after release completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam logic [MULDIV_WIDTH-1:0] DIV0_LO = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Two's-complement sign correction: whole 2*WIDTH value (product) or
// independent halves (remainder/quotient, or a pair of operands).
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic [2*WIDTH-1:0] raw,
  input  logic               split,
  input  logic               neg_hi,
  input  logic               neg_lo,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [2*WIDTH-1:0] raw_neg;
  logic [WIDTH-1:0]   hi_neg;

  always_comb begin
    raw_neg = -raw;
    hi_neg  = -raw[2*WIDTH-1:WIDTH];
    lo      = neg_lo ? raw_neg[WIDTH-1:0] : raw[WIDTH-1:0];
    // Unsplit mode: the upper half follows the full-width negation (borrow from low half).
    if (split) begin
      hi = neg_hi ? hi_neg : raw[2*WIDTH-1:WIDTH];
    end else begin
      hi = neg_lo ? raw_neg[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, sign fixed at completion.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 div0_q, div0_d;

  logic                 op_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     abs_a, abs_b, res_hi, res_lo;
  logic [WIDTH:0]       mul_sum, rem_sh, diff;
  logic                 ge;
  logic [2*WIDTH-1:0]   step;

  always_comb begin
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_abs (
    .raw    ({a, b}),
    .split  (1'b1),
    .neg_hi (a_neg),
    .neg_lo (b_neg),
    .hi     (abs_a),
    .lo     (abs_b)
  );

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd_q};
    ge      = ~diff[WIDTH];
    if (is_div_q) begin
      step = {(ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_res (
    .raw    (step),
    .split  (is_div_q),
    .neg_hi (rem_neg_q),
    .neg_lo (neg_q),
    .hi     (res_hi),
    .lo     (res_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;

    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          hi_d    = res_hi;
          lo_d    = div0_q ? DIV0_LO : res_lo;
        end
      end
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != RUN) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
      if (start) begin
        cnt_d     = '0;
        is_div_d  = op_div;
        neg_d     = a_neg ^ b_neg;
        rem_neg_d = a_neg;
        div0_d    = op_div && (b == '0);
        opnd_d    = op_div ? abs_b : abs_a;
        acc_d     = {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit against a scoreboard of
// expected {HI,LO} results from a behavioural reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] mod_hi = '0;
  logic [31:0] mod_lo = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy;
    int signed   q, r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      OP_MULT:  return sx * sy;
      OP_MULTU: return {32'd0, x} * {32'd0, y};
      OP_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Called at a negedge; leaves the bench at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] e);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int inject_at, output int lat, output int busy_n);
    logic [63:0] e;
    lat = 0;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      if (lat == inject_at) begin
        start = 1'b1;
        op = OP_MULTU;
        a = 32'h0000_0055;
        b = 32'h0000_0077;
        hi_we = 1'b1;
        wdata = 32'h0000_DEAD;
      end else if (lat == inject_at + 1) begin
        start = 1'b0;
        hi_we = 1'b0;
        chk({tag, "_hi_we_busy"}, {32'd0, hi}, {32'd0, mod_hi});
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    e = sb_q.pop_front();
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    mod_hi = e[63:32];
    mod_lo = e[31:0];
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] e);
    int lat, bn;
    issue(o, x, y, e);
    wait_done(tag, -10, lat, bn);
    chk({tag, "_latency"}, 64'(lat + 1), 64'd33);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int lat, bn, dcount;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {busy, done, hi, lo}, 66'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    wait_done("multu_max", -10, lat, bn);
    chk("multu_latency", 64'(lat + 1), 64'd33);
    chk("multu_busy_cycles", 64'(bn), 64'd32);
    chk("multu_busy_at_done", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("multu_done_pulse", {62'd0, busy, done}, 64'd0);

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000});
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu", OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op("div_zero", OP_DIV, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF});
    run_op("divu_zero", OP_DIVU, 32'h8765_4321, 32'd0, {32'h8765_4321, 32'hFFFF_FFFF});
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});

    hi_we = 1'b1; wdata = 32'h0000_CAFE;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_idle", {32'd0, hi}, 64'h0000_CAFE);
    mod_hi = 32'h0000_CAFE;

    issue(OP_DIVU, 32'd1000, 32'd3, {32'd1, 32'd333});
    wait_done("busy_ignore", 5, lat, bn);
    lo_we = 1'b1; wdata = 32'h0000_BEEF;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_after_done", {hi, lo}, {32'd1, 32'h0000_BEEF});
    chk("no_queued_start", {62'd0, busy, done}, 64'd0);

    issue(OP_MULTU, 32'd12345, 32'd6789, model(OP_MULTU, 32'd12345, 32'd6789));
    wait_done("b2b_first", -10, lat, bn);
    issue(OP_MULT, 32'hFFFF_0101, 32'h0000_7F3A, model(OP_MULT, 32'hFFFF_0101, 32'h0000_7F3A));
    chk("b2b_busy_rise", {62'd0, busy, done}, 64'd2);
    wait_done("b2b_second", -10, lat, bn);
    chk("b2b_latency", 64'(lat + 1), 64'd33);
    @(negedge clk);

    issue(OP_DIVU, 32'hFFFF_0000, 32'h0000_0123, model(OP_DIVU, 32'hFFFF_0000, 32'h0000_0123));
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {busy, done, hi, lo}, 66'd0);
    void'(sb_q.pop_front());
    mod_hi = '0;
    mod_lo = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("no_done_after_reset", 64'(dcount), 64'd0);

    run_op("post_reset", OP_DIV, 32'h7654_3210, 32'hFFFF_FFF3, model(OP_DIV, 32'h7654_3210, 32'hFFFF_FFF3));

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
